mod_exp_engine: RTL and testbench
=================================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter W, default 100: width of base, modulus and result (matches partner key width).
REQ-002 SHALL have parameter EW, default 16: width of the exponent (the secret key).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request pulse, sampled on the rising edge of clk.
REQ-006 SHALL have port base, input, W bits: base operand.
REQ-007 SHALL have port exponent, input, EW bits: exponent operand.
REQ-008 SHALL have port modulus, input, W bits: prime modulus.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port result, output, W bits: base^exponent mod modulus; held until the next accepted start.
REQ-012 SHALL have port err, output, 1 bit: operand error flag; valid with done and held with result.

Function
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on the current operation.
REQ-014 SHALL latch base, exponent and modulus on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 SHALL implement states IDLE, LOAD, MUL_R, MUL_B, DONE.
REQ-016 IDLE->LOAD on accepted start; LOAD lasts 1 cycle and sets R=1, B=base, bit index i=0, clears err.
REQ-017 In LOAD, if modulus<2 or base>=modulus: set err=1, result=0, next state DONE.
REQ-018 Per exponent bit i, LSB first, i=0..EW-1: if exponent[i]=1, enter MUL_R (R=R*B mod m); then always enter MUL_B (B=B*B mod m).
REQ-019 Each MUL_R/MUL_B SHALL take exactly W cycles: interleaved shift-add over multiplier bits from MSB to LSB.
REQ-020 Per-cycle modmul step: t=2*acc; if t>=m then t-=m; if multiplier bit set then t+=multiplicand; if t>=m then t-=m.
REQ-021 Internal accumulator SHALL be W+2 bits wide; no intermediate value may overflow.
REQ-022 After MUL_B of bit EW-1: go to DONE; result=R; done=1 for that one cycle; busy=0; return to IDLE.
REQ-023 Latency, accepting edge to done cycle: 2 + W*(EW + popcount(exponent)) cycles; error path: exactly 2 cycles.
REQ-024 exponent=0 SHALL yield result=1 (modulus>=2) with full latency 2+W*EW.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-026 busy SHALL be high exactly in LOAD, MUL_R and MUL_B.

Reset
REQ-027 When rst is high, SHALL force state=IDLE, busy=0, done=0, err=0, result=0, and clear internal registers, independent of clk.
REQ-028 Reset mid-operation SHALL abort with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 W=100, EW=16, base=5, modulus=23, exponent=6 -> result=8, err=0; done exactly 1802 cycles after start; busy high throughout.
REQ-030 base=5, modulus=23, exponent=15 -> result=19; done at cycle 2+100*(16+4)=2002.
REQ-031 exponent=0, base=5, modulus=23 -> result=1 at cycle 1602; modulus=1 -> err=1, result=0, done at cycle 2; base=23, modulus=23 -> err=1.
REQ-032 Second start pulsed at cycle 500 of the exponent=6 run, operands changed, plus start in the DONE cycle -> both ignored; result=8 unchanged; single done pulse.
REQ-033 rst asserted at cycle 900 of a run -> busy=0, done=0, result=0 immediately; no done pulse; a new run after reset with 8^15 mod 23 -> result=2.

Source files
------------

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: computes base^exponent mod modulus with
// right-to-left square-and-multiply. Every modular product is formed by an
// interleaved shift-add multiplier that consumes one multiplier bit per cycle,
// MSB first, so each product takes exactly W cycles.
//
// Control handshake: start is a request pulse sampled on the rising edge and
// accepted only while the FSM is IDLE; operands are captured on that edge.
// busy is high while the operation runs (LOAD, MUL_R, MUL_B), and done pulses
// for exactly one cycle with result/err, which then hold until the next
// completion.
module mod_exp_engine #(
    parameter int W  = 100,
    parameter int EW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exponent,
    input  logic [W-1:0]  modulus,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          err,
    output logic [2:0]    fsm_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL_R = 3'd2,
        MUL_B = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [W-1:0]   b_q;     // running square B (initially the base)
    logic [W-1:0]   r_q;     // running product R
    logic [W-1:0]   m_q;     // latched modulus
    logic [EW-1:0]  e_q;     // latched exponent
    logic [W+1:0]   acc;     // modmul accumulator, always < modulus between steps
    logic [CW-1:0]  cnt;     // multiplier bit currently consumed (MSB first)
    logic [IW-1:0]  idx;     // exponent bit currently processed (LSB first)
    logic [IW-1:0]  next_idx;

    logic [W+1:0]   m_ext;
    logic [W+1:0]   mcand;
    logic           mbit;
    logic [W+1:0]   step;

    assign fsm_state = state;
    assign next_idx  = idx + 1'b1;

    // One shift-add-reduce step of the modular multiplier. B is always the
    // multiplier; the multiplicand is R in MUL_R and B itself in MUL_B.
    always_comb begin
        m_ext = {2'b00, m_q};
        mcand = (state == MUL_R) ? {2'b00, r_q} : {2'b00, b_q};
        mbit  = b_q[cnt];
        step  = acc << 1;
        if (step >= m_ext) step = step - m_ext;
        if (mbit) step = step + mcand;
        if (step >= m_ext) step = step - m_ext;
    end

    // Control FSM with registered outputs and the datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            b_q    <= '0;
            r_q    <= '0;
            m_q    <= '0;
            e_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        b_q   <= base;
                        e_q   <= exponent;
                        m_q   <= modulus;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    r_q <= W'(1);
                    idx <= '0;
                    acc <= '0;
                    cnt <= CW'(W - 1);
                    err <= 1'b0;
                    // A modulus below 2 or an unreduced base cannot be handled.
                    if ((m_q < W'(2)) || (b_q >= m_q)) begin
                        err    <= 1'b1;
                        result <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (e_q[0]) begin
                        state <= MUL_R;
                    end else begin
                        state <= MUL_B;
                    end
                end
                MUL_R: begin
                    if (cnt == '0) begin
                        r_q   <= step[W-1:0];
                        acc   <= '0;
                        cnt   <= CW'(W - 1);
                        state <= MUL_B;
                    end else begin
                        acc <= step;
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL_B: begin
                    if (cnt == '0) begin
                        b_q <= step[W-1:0];
                        acc <= '0;
                        cnt <= CW'(W - 1);
                        if (idx == IW'(EW - 1)) begin
                            result <= r_q;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= next_idx;
                            state <= e_q[next_idx] ? MUL_R : MUL_B;
                        end
                    end else begin
                        acc <= step;
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // start seen here is deliberately dropped.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Testbench for mod_exp_engine: scoreboard of expected {err, result} and
// latency pushed when a request is driven, popped when done pulses.
module tb_mod_exp_engine;

    localparam int W  = 100;
    localparam int EW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  base;
    logic [EW-1:0] exponent;
    logic [W-1:0]  modulus;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          err;
    logic [2:0]    fsm_state;

    int n_tests;
    int n_fail;

    logic [W:0] exp_q[$];   // {err, result}
    int         lat_q[$];

    mod_exp_engine #(.W(W), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .modulus   (modulus),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain square-and-multiply using wide % arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] b, input logic [EW-1:0] e,
                                         input logic [W-1:0] m);
        logic [2*W-1:0] r;
        logic [2*W-1:0] bb;
        if (m < 2 || b >= m) return {1'b1, {W{1'b0}}};
        r  = 1;
        bb = {{W{1'b0}}, b};
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * bb) % {{W{1'b0}}, m};
            bb = (bb * bb) % {{W{1'b0}}, m};
        end
        return {1'b0, r[W-1:0]};
    endfunction

    function automatic int model_lat(input logic [W-1:0] b, input logic [EW-1:0] e,
                                     input logic [W-1:0] m);
        if (m < 2 || b >= m) return 2;
        return 2 + W * (EW + $countones(e));
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v[W-1:0];
    endfunction

    // Driver + monitor for one operation. poke_at: cycle at which a second
    // start with different operands is pulsed (-1 = none). poke_done: pulse
    // start in the done cycle.
    task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input int poke_at,
                          input bit poke_done, input string name);
        int         cyc;
        bit         seen;
        bit         busy_bad;
        logic [W:0] exp_v;
        int         exp_l;
        logic [W-1:0] held;
        exp_q.push_back(model(b, e, m));
        lat_q.push_back(model_lat(b, e, m));
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        start = 1'b0;
        // Operands change right after the accepting edge; must not matter.
        base = rand_wide(); exponent = EW'($urandom); modulus = rand_wide();
        seen = 0;
        busy_bad = 0;
        while (!seen && cyc < 4000) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (cyc == poke_at) begin
                    start = 1'b1;
                    base = rand_wide(); exponent = EW'($urandom); modulus = rand_wide();
                end
                @(posedge clk);
                cyc++;
                #1;
                start = 1'b0;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, cyc, lat_q[0]);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            return;
        end
        exp_v = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL %s busy: dropped low before done, required 1 throughout", name);
        end
        n_tests++;
        if (cyc !== exp_l) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, cyc, exp_l);
        end
        n_tests++;
        if ({err, result} !== exp_v) begin
            n_fail++;
            $display("FAIL %s result: got err=%0b res=%0h, required err=%0b res=%0h",
                     name, err, result, exp_v[W], exp_v[W-1:0]);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %0b, required 0", name, busy);
        end
        held = result;
        if (poke_done) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || result !== held) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%0b res=%0h, required done=0 res=%0h",
                     name, done, result, held);
        end
        if (poke_done) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (busy !== 1'b0 || fsm_state !== 3'd0) begin
                n_fail++;
                $display("FAIL %s start_in_done: got busy=%0b state=%0d, required busy=0 state=0",
                         name, busy, fsm_state);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== '0 || fsm_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b done=%0b err=%0b res=%0h st=%0d, required all 0",
                     busy, done, err, result, fsm_state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(W'(5), EW'(6),  W'(23), -1, 0, "pow_5_6");
        run_op(W'(5), EW'(15), W'(23), -1, 0, "pow_5_15");
        run_op(W'(5), EW'(0),  W'(23), -1, 0, "pow_exp0");
        run_op(W'(7), EW'(16'hffff), W'(101), -1, 0, "pow_all_ones");
    endtask

    task automatic test_errors();
        run_op(W'(5),  EW'(6), W'(1),  -1, 0, "err_mod1");
        run_op(W'(0),  EW'(6), W'(0),  -1, 0, "err_mod0");
        run_op(W'(23), EW'(6), W'(23), -1, 0, "err_base_eq_mod");
        run_op(W'(1),  EW'(3), W'(2),  -1, 0, "mod2_edge");
    endtask

    task automatic test_back_to_back();
        run_op(W'(5), EW'(6), W'(23), 500, 1, "ignore_starts");
        run_op(W'(3), EW'(9), W'(17), -1, 0, "immediate_next");
    endtask

    task automatic test_random();
        logic [W-1:0]  m;
        logic [W-1:0]  b;
        logic [EW-1:0] e;
        for (int k = 0; k < 4; k++) begin
            m = rand_wide();
            m[W-1] = 1'b1;
            b = rand_wide() % m;
            e = EW'($urandom_range(0, 65535));
            run_op(b, e, m, -1, 0, "random");
        end
    endtask

    task automatic test_reset_abort();
        int  cyc;
        bit  saw_done;
        @(negedge clk);
        base = W'(5); exponent = EW'(6); modulus = W'(23); start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        start = 1'b0;
        while (cyc < 900) begin
            @(posedge clk);
            cyc++;
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_async: got busy=%0b done=%0b res=%0h err=%0b, required 0",
                     busy, done, result, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (1200) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        n_tests++;
        if (saw_done || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort_nodone: got done_seen=%0b busy=%0b, required 0 0",
                     saw_done, busy);
        end
        run_op(W'(8), EW'(15), W'(23), -1, 0, "after_reset");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_abort();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
